// File: rtl/tb_ahb5_mem_pkg.sv
// Shared constants, FSM state type and byte-lane helper for the AHB5 memory model.
package tb_ahb5_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Byte strobe for a little-endian 32-bit lane set.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic [2:0] size);
        logic [3:0] m;
        m = 4'b1111;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tb_ahb5_mem_if.sv
// AHB5 manager/subordinate signal bundle for a single manager port.
interface tb_ahb5_mem_if #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hexcl;
    logic [7:0]        hmaster;
    logic [W_DATA-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic              hexokay;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hexcl, hmaster, hwdata,
        input  hready, hresp, hexokay, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hexcl, hmaster, hwdata,
        output hready, hresp, hexokay, hrdata
    );
endinterface

// File: rtl/tb_ahb5_excl_monitor.sv
// Single-entry exclusive-access reservation: set by exclusive reads, cleared by any committed write to the word.
module tb_ahb5_excl_monitor #(
    parameter int unsigned W_WADDR = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic               wr_commit,
    input  logic [W_WADDR-1:0] waddr,
    input  logic [7:0]         master,
    output logic               match_c
);
    logic               res_valid;
    logic [W_WADDR-1:0] res_waddr;
    logic [7:0]         res_master;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_waddr  <= '0;
            res_master <= '0;
        end else if (set) begin
            res_valid  <= 1'b1;
            res_waddr  <= waddr;
            res_master <= master;
        end else if (wr_commit && (waddr == res_waddr)) begin
            res_valid  <= 1'b0;
        end
    end

    assign match_c = res_valid && (res_waddr == waddr) && (res_master == master);

endmodule

// File: rtl/tb_ahb5_mem.sv
// AHB5 subordinate memory model: storage, wait states, error region,
// exclusive monitor and a memory-mapped exit register.
module tb_ahb5_mem
    import tb_ahb5_mem_pkg::*;
#(
    parameter int unsigned       W_ADDR      = 32,
    parameter int unsigned       W_DATA      = 32,
    parameter int unsigned       DEPTH_WORDS = 16384,
    parameter logic [W_ADDR-1:0] BASE_ADDR   = W_ADDR'(32'h0000_0000),
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [W_ADDR-1:0] ERR_BASE    = W_ADDR'(32'hF000_0000),
    parameter logic [W_ADDR-1:0] ERR_SIZE    = W_ADDR'(32'h0000_1000),
    parameter logic [W_ADDR-1:0] EXIT_ADDR   = W_ADDR'(32'h8000_0000),
    parameter string             INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    tb_ahb5_mem_if.slave      bus,
    output logic              exit_valid,
    output logic [W_DATA-1:0] exit_code
);
    localparam int unsigned       W_IDX     = $clog2(DEPTH_WORDS);
    localparam logic [W_ADDR-1:0] MEM_BYTES = W_ADDR'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    logic [W_DATA-1:0] mem [DEPTH_WORDS];

    state_t            state, state_n;
    logic [3:0]        wcnt, wcnt_n;

    logic [W_ADDR-1:0] a_addr;
    logic              a_write, a_excl, a_err, a_exit;
    logic [2:0]        a_size;
    logic [7:0]        a_master;
    logic [W_IDX-1:0]  a_idx;

    logic              accept, acc_err, acc_exit, acc_inmem, acc_inerr, acc_misal;
    logic [W_ADDR-1:0] acc_off, err_off;
    logic              excl_match, wr_ok, rd_excl_done;
    logic [3:0]        wmask;

    // Address-phase decode on the live bus
    assign accept    = bus.hready && ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
    assign acc_off   = bus.haddr - BASE_ADDR;
    assign err_off   = bus.haddr - ERR_BASE;
    assign acc_exit  = (bus.haddr == EXIT_ADDR);
    assign acc_inmem = (acc_off < MEM_BYTES);
    assign acc_inerr = (ERR_SIZE != '0) && (err_off < ERR_SIZE);
    assign acc_misal = ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) ||
                       ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));
    assign acc_err   = (bus.hsize > HSIZE_WORD) || acc_misal || acc_inerr ||
                       (!acc_inmem && !acc_exit) || (acc_exit && (bus.hsize != HSIZE_WORD));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr   <= '0;
            a_write  <= 1'b0;
            a_size   <= HSIZE_BYTE;
            a_excl   <= 1'b0;
            a_master <= '0;
            a_err    <= 1'b0;
            a_exit   <= 1'b0;
        end else if (accept) begin
            a_addr   <= bus.haddr;
            a_write  <= bus.hwrite;
            a_size   <= bus.hsize;
            a_excl   <= bus.hexcl;
            a_master <= bus.hmaster;
            a_err    <= acc_err;
            a_exit   <= acc_exit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        case (state)
            ST_WAIT: begin
                if (wcnt == 4'd0) state_n = a_err ? ST_ERR1 : ST_DATA;
                else              wcnt_n  = wcnt - 4'd1;
            end
            ST_ERR1: state_n = ST_ERR2;
            default: begin
                if (accept) begin
                    if (WAIT_STATES != 0) begin
                        state_n = ST_WAIT;
                        wcnt_n  = WAIT_INIT;
                    end else begin
                        state_n = acc_err ? ST_ERR1 : ST_DATA;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    tb_ahb5_excl_monitor #(.W_WADDR(W_ADDR - 2)) u_excl (
        .clk       (clk),
        .rst       (rst),
        .set       (rd_excl_done),
        .wr_commit (wr_ok),
        .waddr     (a_addr[W_ADDR-1:2]),
        .master    (a_master),
        .match_c   (excl_match)
    );

    // Commit happens on the edge that ends DATA; failed exclusives never reach it
    assign wr_ok        = (state == ST_DATA) && a_write && (!a_excl || excl_match);
    assign rd_excl_done = (state == ST_DATA) && !a_write && a_excl;
    assign a_idx        = W_IDX'((a_addr - BASE_ADDR) >> 2);
    assign wmask        = lane_mask(a_addr[1:0], a_size);

    // Storage write port; storage itself has no reset
    always_ff @(posedge clk) begin
        if (wr_ok && !a_exit && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[a_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exit_valid <= 1'b0;
            exit_code  <= '0;
        end else if (wr_ok && a_exit) begin
            exit_valid <= 1'b1;
            exit_code  <= bus.hwdata;
        end
    end

    assign bus.hready  = !((state == ST_WAIT) || (state == ST_ERR1));
    assign bus.hresp   = (state == ST_ERR1) || (state == ST_ERR2);
    assign bus.hexokay = (state == ST_DATA) && a_excl && (!a_write || excl_match);
    assign bus.hrdata  = ((state == ST_DATA) && !a_write) ? (a_exit ? exit_code : mem[a_idx]) : '0;

endmodule

// File: tb/tb_tb_ahb5_mem.sv
// Scoreboard bench for tb_ahb5_mem: a zero-wait instance and a three-wait instance.
module tb_tb_ahb5_mem;
    import tb_ahb5_mem_pkg::*;

    localparam logic [31:0] ERR_BASE  = 32'hF000_0000;
    localparam logic [31:0] EXIT_ADDR = 32'h8000_0000;

    typedef struct {
        string       tag;
        bit          write;
        bit          err;
        bit          exok;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev0, ev1;
    logic [31:0] ec0, ec1;
    exp_t        q0[$];
    exp_t        q1[$];
    int          st [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;

    tb_ahb5_mem_if #(.W_ADDR(32), .W_DATA(32)) b0 ();
    tb_ahb5_mem_if #(.W_ADDR(32), .W_DATA(32)) b1 ();

    tb_ahb5_mem #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave), .exit_valid(ev0), .exit_code(ec0)
    );
    tb_ahb5_mem #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave), .exit_valid(ev1), .exit_code(ec1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_addr(input int d, input logic [31:0] addr, input bit wr,
                              input logic [2:0] size, input bit excl, input logic [7:0] mst,
                              input logic [1:0] trans);
        if (d == 0) begin
            b0.haddr = addr; b0.hwrite = wr; b0.hsize = size;
            b0.hexcl = excl; b0.hmaster = mst; b0.htrans = trans;
        end else begin
            b1.haddr = addr; b1.hwrite = wr; b1.hsize = size;
            b1.hexcl = excl; b1.hmaster = mst; b1.htrans = trans;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? b0.hready : b1.hready;
    endfunction

    // One pipelined transfer; call at a negedge, returns at the negedge inside its data phase
    task automatic xf(input int d, input string tag, input logic [31:0] addr, input bit wr,
                      input logic [2:0] size, input bit excl, input logic [7:0] mst,
                      input logic [31:0] wdata, input bit err, input bit exok,
                      input logic [31:0] rdata);
        exp_t e;
        int   n;
        drive_addr(d, addr, wr, size, excl, mst, HTRANS_NONSEQ);
        n = 0;
        while (!rdy(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout actual=%0d required=<50", tag, n);
        end
        @(posedge clk);
        e.tag = tag; e.write = wr; e.err = err; e.exok = exok; e.rdata = rdata;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        if (d == 0) b0.hwdata = wdata;
        else        b1.hwdata = wdata;
        drive_addr(d, 32'h0, 1'b0, HSIZE_WORD, 1'b0, 8'h00, HTRANS_IDLE);
    endtask

    task automatic rd(input int d, input string tag, input logic [31:0] addr, input logic [31:0] exp);
        xf(d, tag, addr, 1'b0, HSIZE_WORD, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, exp);
    endtask

    task automatic wr(input int d, input string tag, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] data);
        xf(d, tag, addr, 1'b1, size, 1'b0, 8'h00, data, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic er(input int d, input string tag, input logic [31:0] addr, input bit w,
                      input logic [2:0] size);
        xf(d, tag, addr, w, size, 1'b0, 8'h00, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic ex(input string tag, input bit w, input logic [7:0] mst,
                      input logic [31:0] data, input bit ok, input logic [31:0] exp);
        xf(0, tag, 32'h100, w, HSIZE_WORD, 1'b1, mst, data, 1'b0, ok, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Response monitor: counts stall cycles and checks the completing cycle
    task automatic mon(input int d);
        exp_t        e;
        logic        ready, resp, exok;
        logic [31:0] rdata;
        int          w;
        w     = (d == 0) ? 0 : 3;
        ready = (d == 0) ? b0.hready  : b1.hready;
        resp  = (d == 0) ? b0.hresp   : b1.hresp;
        exok  = (d == 0) ? b0.hexokay : b1.hexokay;
        rdata = (d == 0) ? b0.hrdata  : b1.hrdata;
        if (d == 0 && q0.size() == 0) return;
        if (d == 1 && q1.size() == 0) return;
        e = (d == 0) ? q0[0] : q1[0];
        if (!ready) begin
            check({e.tag, "_stall_hresp"}, 32'(resp), 32'(e.err && (st[d] == w)));
            if (st[d] >= w + int'(e.err)) check({e.tag, "_stall_count"}, st[d] + 1, w + int'(e.err));
            st[d]++;
        end else begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            check({e.tag, "_stalls"}, st[d], w + int'(e.err));
            check({e.tag, "_hresp"}, 32'(resp), 32'(e.err));
            check({e.tag, "_hexokay"}, 32'(exok), 32'(e.exok));
            if (!e.write) check({e.tag, "_hrdata"}, rdata, e.err ? 32'h0 : e.rdata);
            st[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        drive_addr(0, 32'h0, 1'b0, HSIZE_WORD, 1'b0, 8'h00, HTRANS_IDLE);
        drive_addr(1, 32'h0, 1'b0, HSIZE_WORD, 1'b0, 8'h00, HTRANS_IDLE);
        b0.hwdata = 32'h0;
        b1.hwdata = 32'h0;
        rst = 1'b1;
        idle(3);
        check("rst_hready",  32'(b0.hready),  32'd1);
        check("rst_hresp",   32'(b0.hresp),   32'd0);
        check("rst_hexokay", 32'(b0.hexokay), 32'd0);
        check("rst_hrdata",  b0.hrdata,       32'h0);
        check("rst_exit_v",  32'(ev0),        32'd0);
        check("rst_exit_c",  ec0,             32'h0);
        check("rst_hready1", 32'(b1.hready),  32'd1);
        rst = 1'b0;
        idle(1);

        // Back-to-back write then read of the same word
        wr(0, "w40", 32'h40, HSIZE_WORD, 32'hDEAD_BEEF);
        rd(0, "r40", 32'h40, 32'hDEAD_BEEF);
        // Byte and halfword lane merging
        wr(0, "w40z", 32'h40, HSIZE_WORD, 32'h0);
        wr(0, "wb43", 32'h43, HSIZE_BYTE, 32'hA500_0000);
        rd(0, "r40b", 32'h40, 32'hA500_0000);
        wr(0, "w40r", 32'h40, HSIZE_WORD, 32'hDEAD_BEEF);
        wr(0, "w44z", 32'h44, HSIZE_WORD, 32'h0);
        wr(0, "wh46", 32'h46, HSIZE_HALF, 32'h1234_0000);
        wr(0, "wb44", 32'h44, HSIZE_BYTE, 32'h0000_0077);
        wr(0, "wb45", 32'h45, HSIZE_BYTE, 32'h0000_9900);
        rd(0, "r44",  32'h44, 32'h1234_9977);
        // Top word of storage, then the first address past it
        wr(0, "wtop", 32'hFFFC, HSIZE_WORD, 32'h1234_5678);
        rd(0, "rtop", 32'hFFFC, 32'h1234_5678);
        // Error responses; none may disturb storage
        er(0, "e_reg",  ERR_BASE + 32'h4, 1'b0, HSIZE_WORD);
        er(0, "e_half", 32'h41, 1'b0, HSIZE_HALF);
        er(0, "e_whlf", 32'h41, 1'b1, HSIZE_HALF);
        er(0, "e_sz3",  32'h40, 1'b1, 3'd3);
        er(0, "e_oob",  32'h1_0000, 1'b0, HSIZE_WORD);
        er(0, "e_exb",  EXIT_ADDR, 1'b1, HSIZE_BYTE);
        rd(0, "r40e", 32'h40, 32'hDEAD_BEEF);
        idle(1);

        // Exclusive monitor
        wr(0, "w100", 32'h100, HSIZE_WORD, 32'h5);
        ex("xr1", 1'b0, 8'h00, 32'h0, 1'b1, 32'h5);
        ex("xw1", 1'b1, 8'h00, 32'hA, 1'b1, 32'h0);
        rd(0, "r100a", 32'h100, 32'hA);
        ex("xr2", 1'b0, 8'h00, 32'h0, 1'b1, 32'hA);
        wr(0, "w100b", 32'h100, HSIZE_WORD, 32'hB);
        ex("xw2", 1'b1, 8'h00, 32'hC, 1'b0, 32'h0);
        rd(0, "r100b", 32'h100, 32'hB);
        ex("xr3", 1'b0, 8'h01, 32'h0, 1'b1, 32'hB);
        ex("xw3m", 1'b1, 8'h02, 32'hE, 1'b0, 32'h0);
        ex("xw3", 1'b1, 8'h01, 32'hD, 1'b1, 32'h0);
        rd(0, "r100d", 32'h100, 32'hD);
        idle(1);

        // BUSY must not start a data phase
        drive_addr(0, ERR_BASE, 1'b0, HSIZE_WORD, 1'b0, 8'h00, HTRANS_BUSY);
        idle(1);
        drive_addr(0, 32'h0, 1'b0, HSIZE_WORD, 1'b0, 8'h00, HTRANS_IDLE);
        check("busy_hready", 32'(b0.hready), 32'd1);
        check("busy_hresp",  32'(b0.hresp),  32'd0);

        // Exit register
        wr(0, "wexit1", EXIT_ADDR, HSIZE_WORD, 32'h1);
        idle(1);
        check("exit_v1", 32'(ev0), 32'd1);
        check("exit_c1", ec0, 32'h1);
        rd(0, "rexit", EXIT_ADDR, 32'h1);
        wr(0, "wexit2", EXIT_ADDR, HSIZE_WORD, 32'h2);
        idle(1);
        check("exit_v2", 32'(ev0), 32'd1);
        check("exit_c2", ec0, 32'h2);

        // Reset during a write data phase: no commit, exit cleared, storage kept
        wr(0, "w80a", 32'h80, HSIZE_WORD, 32'h1111_1111);
        wr(0, "w80b", 32'h80, HSIZE_WORD, 32'h2222_2222);
        rst = 1'b1;
        idle(2);
        check("rst2_exit_v", 32'(ev0), 32'd0);
        check("rst2_exit_c", ec0, 32'h0);
        check("rst2_hready", 32'(b0.hready), 32'd1);
        rst = 1'b0;
        idle(1);
        rd(0, "r40rst", 32'h40, 32'hDEAD_BEEF);
        rd(0, "r80rst", 32'h80, 32'h1111_1111);
        idle(2);

        // Three wait states
        wr(1, "w3_40", 32'h40, HSIZE_WORD, 32'hCAFE_F00D);
        rd(1, "r3_40", 32'h40, 32'hCAFE_F00D);
        er(1, "e3_reg", ERR_BASE, 1'b0, HSIZE_WORD);
        rd(1, "r3_40b", 32'h40, 32'hCAFE_F00D);
        idle(8);
        check("exit_v_ws3", 32'(ev1), 32'd0);
        check("exit_c_ws3", ec1, 32'h0);
        check("queues_drained", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
